ceespu_gpu_blit_ctrl: RTL and testbench

- Command-driven clear/fill/scroll engine for the GPU text RAM and colour RAM.
- Owns port A of both RAMs and arbitrates it between CPU bus writes (posted, never stalled) and its own word-wide read/write sequences.
- Sits between the system bus decode and the text/colour RAMs. Lets software scroll or clear the 80x25 screen without 1000 individual stores.

---
 rtl/ceespu_gpu_pkg.sv | 45 ++++
 rtl/ceespu_gpu_port_arb.sv | 56 +++++
 rtl/ceespu_gpu_blit_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ceespu_gpu_blit_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceespu_gpu_pkg.sv
// Shared GPU constants: screen geometry, RAM window bases, blit command
// encodings, the port-A request payload and small address helpers.
package ceespu_gpu_pkg;

  localparam int unsigned ROWS           = 25;
  localparam int unsigned TEXT_ROW_WORDS = 20;
  localparam int unsigned COL_ROW_WORDS  = 40;

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] TEXT_BASE = 16'hF800;
  localparam logic [ADDR_W-1:0] COL_BASE  = 16'hE000;

  localparam logic [1:0] OP_CLEAR   = 2'd0;
  localparam logic [1:0] OP_SCROLL  = 2'd1;
  localparam logic [1:0] OP_FILLROW = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  localparam logic REGION_TEXT = 1'b0;
  localparam logic REGION_COL  = 1'b1;

  // One port-A access: byte write enables, read strobe, byte address, data.
  typedef struct packed {
    logic [BE_W-1:0]   we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } port_req_t;

  // 32-bit words per screen row for the selected region.
  function automatic logic [IDX_W-1:0] row_words(input logic region);
    return (region == REGION_COL) ? IDX_W'(COL_ROW_WORDS) : IDX_W'(TEXT_ROW_WORDS);
  endfunction

  // Byte address of word idx, wrapping at 16 bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/ceespu_gpu_port_arb.sv
// Registered 2:1 arbiter for RAM port A. The CPU wins any cycle it drives a
// non-zero byte enable; otherwise the engine request is forwarded.
// Ports:
//   I_clk, I_rstn               clock, async active-low reset
//   I_sys_*                     CPU posted write request
//   eng_*                       engine request (write enables, read strobe, addr, data)
//   eng_grant_c                 combinational: engine owns the port this cycle
//   O_ram_*                     registered port A pins
module ceespu_gpu_port_arb
  import ceespu_gpu_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_rstn,
  input  logic [BE_W-1:0]   I_sys_write_enable,
  input  logic [ADDR_W-1:0] I_sys_address,
  input  logic [DATA_W-1:0] I_sys_data,
  input  logic [BE_W-1:0]   eng_write_enable,
  input  logic              eng_read_enable,
  input  logic [ADDR_W-1:0] eng_address,
  input  logic [DATA_W-1:0] eng_data,
  output logic              eng_grant_c,
  output logic [BE_W-1:0]   O_ram_write_enable,
  output logic              O_ram_read_enable,
  output logic [ADDR_W-1:0] O_ram_address,
  output logic [DATA_W-1:0] O_ram_data
);

  port_req_t cpu_req, eng_req, port_d, port_q;

  assign eng_grant_c = (I_sys_write_enable == '0);

  // Request selection; CPU writes never carry a read strobe.
  always_comb begin
    cpu_req.we   = I_sys_write_enable;
    cpu_req.re   = 1'b0;
    cpu_req.addr = I_sys_address;
    cpu_req.data = I_sys_data;
    eng_req.we   = eng_write_enable;
    eng_req.re   = eng_read_enable;
    eng_req.addr = eng_address;
    eng_req.data = eng_data;
    port_d       = eng_grant_c ? eng_req : cpu_req;
  end

  // Port pins register.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) port_q <= '0;
    else         port_q <= port_d;
  end

  assign O_ram_write_enable = port_q.we;
  assign O_ram_read_enable  = port_q.re;
  assign O_ram_address      = port_q.addr;
  assign O_ram_data         = port_q.data;

endmodule

// File: rtl/ceespu_gpu_blit_ctrl.sv
// Clear / fill-row / scroll-up engine for the GPU text and colour RAMs.
// Owns RAM port A and shares it with posted CPU writes, which always win.
// Ports:
//   I_clk, I_rstn        clock, async active-low reset
//   I_sys_*              CPU write request (byte enables, byte address, data)
//   I_cmd_*              command strobe, op, region, row, fill word
//   O_cmd_ready, O_busy  engine idle / active
//   O_done               one-cycle pulse when a command finishes
//   O_ram_*              registered port A pins
//   I_ram_rdata          read data, present in the cycle the registered read
//                        strobe is on the pins (the cycle after issue)
module ceespu_gpu_blit_ctrl
  import ceespu_gpu_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_rstn,
  input  logic [BE_W-1:0]   I_sys_write_enable,
  input  logic [ADDR_W-1:0] I_sys_address,
  input  logic [DATA_W-1:0] I_sys_data,
  input  logic              I_cmd_valid,
  input  logic [1:0]        I_cmd_op,
  input  logic              I_cmd_region,
  input  logic [ROW_W-1:0]  I_cmd_row,
  input  logic [DATA_W-1:0] I_cmd_fill,
  output logic              O_cmd_ready,
  output logic              O_busy,
  output logic              O_done,
  output logic [BE_W-1:0]   O_ram_write_enable,
  output logic              O_ram_read_enable,
  output logic [ADDR_W-1:0] O_ram_address,
  output logic [DATA_W-1:0] O_ram_data,
  input  logic [DATA_W-1:0] I_ram_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SC_RD = 3'd2;
  localparam logic [2:0] S_SC_WR = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  end_q, end_d;
  logic [IDX_W-1:0]  rw_q, rw_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              eng_grant_c;
  logic [BE_W-1:0]   eng_we;
  logic              eng_re;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_data;

  logic [IDX_W-1:0]  acc_rw, acc_last, acc_row_start;

  // Geometry of the command being offered.
  assign acc_rw        = row_words(I_cmd_region);
  assign acc_last      = IDX_W'(ROWS) * acc_rw - IDX_W'(1);
  assign acc_row_start = IDX_W'(I_cmd_row) * acc_rw;

  // State and datapath registers.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      end_q   <= '0;
      rw_q    <= '0;
      base_q  <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      rw_q    <= rw_d;
      base_q  <= base_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, engine request; every step holds while the CPU owns the port.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    end_d    = end_q;
    rw_d     = rw_q;
    base_d   = base_q;
    fill_d   = fill_q;
    data_d   = data_q;
    first_d  = 1'b0;
    eng_we   = '0;
    eng_re   = 1'b0;
    eng_addr = word_addr(base_q, idx_q);
    eng_data = fill_q;

    case (state_q)
      S_IDLE: begin
        if (I_cmd_valid && (I_cmd_op != OP_RSVD)) begin
          fill_d = I_cmd_fill;
          rw_d   = acc_rw;
          base_d = (I_cmd_region == REGION_COL) ? COL_BASE : TEXT_BASE;
          case (I_cmd_op)
            OP_CLEAR: begin
              idx_d   = '0;
              end_d   = acc_last;
              state_d = S_FILL;
            end
            OP_FILLROW: begin
              if (I_cmd_row >= ROW_W'(ROWS)) begin
                state_d = S_FIN;
              end else begin
                idx_d   = acc_row_start;
                end_d   = acc_row_start + acc_rw - IDX_W'(1);
                state_d = S_FILL;
              end
            end
            OP_SCROLL: begin
              idx_d   = acc_rw;
              end_d   = acc_last;
              state_d = S_SC_RD;
            end
            default: ;
          endcase
        end
      end

      S_FILL: begin
        eng_we = 4'hF;
        if (eng_grant_c) begin
          if (idx_q == end_q) state_d = S_FIN;
          else                idx_d   = idx_q + IDX_W'(1);
        end
      end

      S_SC_RD: begin
        eng_re = 1'b1;
        if (eng_grant_c) begin
          first_d = 1'b1;
          state_d = S_SC_WR;
        end
      end

      S_SC_WR: begin
        // Read data is only on the bus in the first cycle: capture it and
        // bypass it straight to the write so no cycle is lost.
        if (first_q) data_d = I_ram_rdata;
        eng_we   = 4'hF;
        eng_addr = word_addr(base_q, idx_q - rw_q);
        eng_data = first_q ? I_ram_rdata : data_q;
        if (eng_grant_c) begin
          if (idx_q == end_q) begin
            // Bottom row is blanked with the fill word.
            idx_d   = end_q - rw_q + IDX_W'(1);
            state_d = S_FILL;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SC_RD;
          end
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  assign O_busy      = busy_q;
  assign O_cmd_ready = !busy_q;
  assign O_done      = done_q;

  ceespu_gpu_port_arb u_port_arb (
    .I_clk              (I_clk),
    .I_rstn             (I_rstn),
    .I_sys_write_enable (I_sys_write_enable),
    .I_sys_address      (I_sys_address),
    .I_sys_data         (I_sys_data),
    .eng_write_enable   (eng_we),
    .eng_read_enable    (eng_re),
    .eng_address        (eng_addr),
    .eng_data           (eng_data),
    .eng_grant_c        (eng_grant_c),
    .O_ram_write_enable (O_ram_write_enable),
    .O_ram_read_enable  (O_ram_read_enable),
    .O_ram_address      (O_ram_address),
    .O_ram_data         (O_ram_data)
  );

endmodule

// File: tb/tb_ceespu_gpu_blit_ctrl.sv
// Directed bench for ceespu_gpu_blit_ctrl with behavioural text/colour RAMs
// attached to port A.
module tb_ceespu_gpu_blit_ctrl;

  logic        I_clk;
  logic        I_rstn;
  logic [3:0]  I_sys_write_enable;
  logic [15:0] I_sys_address;
  logic [31:0] I_sys_data;
  logic        I_cmd_valid;
  logic [1:0]  I_cmd_op;
  logic        I_cmd_region;
  logic [4:0]  I_cmd_row;
  logic [31:0] I_cmd_fill;
  logic        O_cmd_ready;
  logic        O_busy;
  logic        O_done;
  logic [3:0]  O_ram_write_enable;
  logic        O_ram_read_enable;
  logic [15:0] O_ram_address;
  logic [31:0] O_ram_data;
  logic [31:0] I_ram_rdata;

  ceespu_gpu_blit_ctrl dut (
    .I_clk              (I_clk),
    .I_rstn             (I_rstn),
    .I_sys_write_enable (I_sys_write_enable),
    .I_sys_address      (I_sys_address),
    .I_sys_data         (I_sys_data),
    .I_cmd_valid        (I_cmd_valid),
    .I_cmd_op           (I_cmd_op),
    .I_cmd_region       (I_cmd_region),
    .I_cmd_row          (I_cmd_row),
    .I_cmd_fill         (I_cmd_fill),
    .O_cmd_ready        (O_cmd_ready),
    .O_busy             (O_busy),
    .O_done             (O_done),
    .O_ram_write_enable (O_ram_write_enable),
    .O_ram_read_enable  (O_ram_read_enable),
    .O_ram_address      (O_ram_address),
    .O_ram_data         (O_ram_data),
    .I_ram_rdata        (I_ram_rdata)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Behavioural RAMs: written on the negedge from the pins, read combinationally.
  logic [31:0] text_mem [0:511];
  logic [31:0] col_mem  [0:1023];
  logic [15:0] toff, coff;
  assign toff = O_ram_address - 16'hF800;
  assign coff = O_ram_address - 16'hE000;
  assign I_ram_rdata = (O_ram_address >= 16'hF800) ? text_mem[toff[10:2]] :
                       (O_ram_address >= 16'hE000 && O_ram_address < 16'hF000) ? col_mem[coff[11:2]] :
                       32'h0;

  int          tb_req = 0;     // 1 clear stats, 2 also preload text, 3 also preload colour
  logic [31:0] hit_data = '0;  // writes carrying this word are tallied per text word
  int          wr_count;
  int          done_count;
  logic [15:0] wr_min, wr_max;
  int          hit [0:511];

  always @(negedge I_clk) begin
    if (tb_req != 0) begin
      wr_count   <= 0;
      done_count <= 0;
      wr_min     <= 16'hFFFF;
      wr_max     <= 16'h0000;
      for (int k = 0; k < 512; k++) hit[k] <= 0;
      if (tb_req == 2) for (int k = 0; k < 512; k++) text_mem[k] <= 32'(k);
      if (tb_req == 3) for (int k = 0; k < 1024; k++) col_mem[k] <= 32'(k);
    end else begin
      if (O_ram_write_enable != 4'h0) begin
        wr_count <= wr_count + 1;
        if (O_ram_address < wr_min) wr_min <= O_ram_address;
        if (O_ram_address > wr_max) wr_max <= O_ram_address;
        for (int b = 0; b < 4; b++) begin
          if (O_ram_write_enable[b]) begin
            if (O_ram_address >= 16'hF800)
              text_mem[toff[10:2]][8*b +: 8] <= O_ram_data[8*b +: 8];
            else if (O_ram_address >= 16'hE000 && O_ram_address < 16'hF000)
              col_mem[coff[11:2]][8*b +: 8] <= O_ram_data[8*b +: 8];
          end
        end
        if (O_ram_address >= 16'hF800 && O_ram_data == hit_data)
          hit[toff[10:2]] <= hit[toff[10:2]] + 1;
      end
      if (O_done) done_count <= done_count + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge I_clk);
      #1;
    end
  endtask

  task automatic tb_op(input int code);
    tb_req = code;
    @(negedge I_clk);
    #1;
    tb_req = 0;
  endtask

  int t0;

  task automatic issue(input logic [1:0] op, input logic region, input logic [4:0] row,
                       input logic [31:0] fill);
    I_cmd_valid  = 1'b1;
    I_cmd_op     = op;
    I_cmd_region = region;
    I_cmd_row    = row;
    I_cmd_fill   = fill;
    @(posedge I_clk);
    #1;
    I_cmd_valid  = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    int n = 0;
    while (!O_done && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, 32'(O_done), 32'd1);
    lat = cyc - t0 + 1;
  endtask

  int          lat, errs, n_cpu, cpu_err, j;
  logic [31:0] cpu_dat, last_cpu;
  logic        cpu_on;

  initial begin
    I_rstn = 1'b0;
    I_sys_write_enable = '0;
    I_sys_address = '0;
    I_sys_data = '0;
    I_cmd_valid = 1'b0;
    I_cmd_op = '0;
    I_cmd_region = 1'b0;
    I_cmd_row = '0;
    I_cmd_fill = '0;
    step(3);

    // Reset state
    check_val("rst_busy",  32'(O_busy), 32'd0);
    check_val("rst_ready", 32'(O_cmd_ready), 32'd1);
    check_val("rst_done",  32'(O_done), 32'd0);
    check_val("rst_we",    32'(O_ram_write_enable), 32'd0);
    check_val("rst_re",    32'(O_ram_read_enable), 32'd0);
    check_val("rst_addr",  32'(O_ram_address), 32'd0);
    check_val("rst_data",  O_ram_data, 32'd0);
    @(negedge I_clk);
    I_rstn = 1'b1;
    step(2);

    // CLEAR text
    tb_op(1);
    issue(2'd0, 1'b0, 5'd0, 32'h20202020);
    check_val("clr_ready_busy", 32'(O_cmd_ready), 32'd0);
    wait_done("clr_done", 2000, lat);
    step(3);
    check_val("clr_latency", 32'(lat), 32'd501);
    check_val("clr_writes",  32'(wr_count), 32'd500);
    check_val("clr_min",     32'(wr_min), 32'h0000F800);
    check_val("clr_max",     32'(wr_max), 32'h0000FFCC);
    check_val("clr_w0",      text_mem[0], 32'h20202020);
    check_val("clr_w499",    text_mem[499], 32'h20202020);
    check_val("clr_ndone",   32'(done_count), 32'd1);

    // FILL_ROW colour row 3
    tb_op(3);
    issue(2'd2, 1'b1, 5'd3, 32'h1F001F00);
    wait_done("frow_done", 200, lat);
    step(3);
    check_val("frow_latency", 32'(lat), 32'd41);
    check_val("frow_writes",  32'(wr_count), 32'd40);
    check_val("frow_min",     32'(wr_min), 32'h0000E1E0);
    check_val("frow_max",     32'(wr_max), 32'h0000E27C);
    check_val("frow_w120",    col_mem[120], 32'h1F001F00);
    check_val("frow_w159",    col_mem[159], 32'h1F001F00);
    check_val("frow_row2",    col_mem[119], 32'd119);
    check_val("frow_row4",    col_mem[160], 32'd160);

    // SCROLL_UP text, with a CLEAR offered while busy
    tb_op(2);
    issue(2'd1, 1'b0, 5'd0, 32'h2E2E2E2E);
    step(10);
    I_cmd_valid = 1'b1;
    I_cmd_op    = 2'd0;
    I_cmd_fill  = 32'hDEADBEEF;
    check_val("scr_ready_busy", 32'(O_cmd_ready), 32'd0);
    step(1);
    I_cmd_valid = 1'b0;
    wait_done("scr_done", 3000, lat);
    step(3);
    check_val("scr_latency", 32'(lat), 32'd981);
    check_val("scr_writes",  32'(wr_count), 32'd500);
    check_val("scr_ndone",   32'(done_count), 32'd1);
    errs = 0;
    for (int k = 0; k < 480; k++) if (text_mem[k] !== 32'(k + 20)) errs++;
    for (int k = 480; k < 500; k++) if (text_mem[k] !== 32'h2E2E2E2E) errs++;
    check_val("scr_body_errs", 32'(errs), 32'd0);
    check_val("scr_w0",   text_mem[0], 32'd20);
    check_val("scr_w479", text_mem[479], 32'd499);
    check_val("scr_w480", text_mem[480], 32'h2E2E2E2E);

    // Reserved op is dropped
    tb_op(1);
    issue(2'd3, 1'b0, 5'd0, 32'h12345678);
    step(5);
    check_val("rsv_writes", 32'(wr_count), 32'd0);
    check_val("rsv_ndone",  32'(done_count), 32'd0);
    check_val("rsv_busy",   32'(O_busy), 32'd0);

    // CLEAR with CPU writes to F804 every third cycle
    tb_op(2);
    hit_data = 32'h41414141;
    issue(2'd0, 1'b0, 5'd0, 32'h41414141);
    n_cpu = 0;
    cpu_err = 0;
    last_cpu = '0;
    j = 0;
    while (!O_done && j < 2000) begin
      cpu_on = (j % 3 == 0) && (j < 300);
      cpu_dat = 32'hC0DE0000 + 32'(j);
      if (cpu_on) begin
        I_sys_write_enable = 4'hF;
        I_sys_address = 16'hF804;
        I_sys_data = cpu_dat;
        n_cpu++;
        last_cpu = cpu_dat;
      end else begin
        I_sys_write_enable = 4'h0;
      end
      step(1);
      if (cpu_on && (O_ram_write_enable !== 4'hF || O_ram_address !== 16'hF804 ||
                     O_ram_data !== cpu_dat || O_ram_read_enable !== 1'b0)) cpu_err++;
      j++;
    end
    I_sys_write_enable = 4'h0;
    check_val("cpu_done", 32'(O_done), 32'd1);
    lat = cyc - t0 + 1;
    step(3);
    check_val("cpu_passthru_errs", 32'(cpu_err), 32'd0);
    check_val("cpu_latency", 32'(lat), 32'(501 + n_cpu));
    errs = 0;
    for (int k = 0; k < 500; k++) if (hit[k] != 1) errs++;
    check_val("cpu_eng_word_errs", 32'(errs), 32'd0);
    check_val("cpu_w1_last",  text_mem[1], last_cpu);
    check_val("cpu_w0",       text_mem[0], 32'h41414141);
    check_val("cpu_w499",     text_mem[499], 32'h41414141);

    // Reset in the middle of a colour CLEAR
    tb_op(3);
    issue(2'd0, 1'b1, 5'd0, 32'h5A5A5A5A);
    j = 0;
    while (wr_count < 100 && j < 2000) begin
      @(negedge I_clk);
      j++;
    end
    #2;
    I_rstn = 1'b0;
    #1;
    check_val("arst_busy",  32'(O_busy), 32'd0);
    check_val("arst_done",  32'(O_done), 32'd0);
    check_val("arst_we",    32'(O_ram_write_enable), 32'd0);
    check_val("arst_re",    32'(O_ram_read_enable), 32'd0);
    check_val("arst_addr",  32'(O_ram_address), 32'd0);
    check_val("arst_data",  O_ram_data, 32'd0);
    @(negedge I_clk);
    I_rstn = 1'b1;
    #1;
    check_val("arst_ready", 32'(O_cmd_ready), 32'd1);
    check_val("arst_partial_first", col_mem[0], 32'h5A5A5A5A);
    check_val("arst_partial_last",  col_mem[999], 32'd999);

    // Normal command after reset: FILL_ROW text, last row
    tb_op(1);
    issue(2'd2, 1'b0, 5'd24, 32'h77777777);
    wait_done("frow24_done", 200, lat);
    step(3);
    check_val("frow24_latency", 32'(lat), 32'd21);
    check_val("frow24_writes",  32'(wr_count), 32'd20);
    check_val("frow24_min",     32'(wr_min), 32'h0000FF80);
    check_val("frow24_max",     32'(wr_max), 32'h0000FFCC);
    check_val("frow24_w480",    text_mem[480], 32'h77777777);

    // FILL_ROW with an off-screen row: no writes, done still pulses
    tb_op(1);
    issue(2'd2, 1'b0, 5'd30, 32'h99999999);
    wait_done("frow30_done", 20, lat);
    step(3);
    check_val("frow30_latency", 32'(lat), 32'd1);
    check_val("frow30_writes",  32'(wr_count), 32'd0);
    check_val("frow30_ndone",   32'(done_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
